// File: rtl/divisor_iterativo_pkg.sv
// Shared definitions for the iterative divider.
//   - FSM state encodings (IDLE / RUN / DONE)
//   - default operand widths
//   - quotient value reported on a divide-by-zero (all ones)
package divisor_iterativo_pkg;

  localparam int NB_DATA_DEF = 6;
  localparam int NB_DIV_DEF  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Quotient reported when the divisor is zero: every bit set.
  function automatic logic [NB_DATA_DEF-1:0] coc_div_cero();
    return {NB_DATA_DEF{1'b1}};
  endfunction

endpackage

// File: rtl/divisor_iterativo_restador_comparador.sv
// Combinational compare/subtract step of the divider.
// Ports:
//   rem   : current remainder accumulator (NB_DATA bits)
//   div   : divisor (NB_DIV bits, zero-extended internally)
//   o_ge  : rem >= div
//   o_dif : rem - div (meaningful only when o_ge is high)
module restador_comparador #(
  parameter int NB_DATA = 6,
  parameter int NB_DIV  = 3
) (
  input  logic [NB_DATA-1:0] rem,
  input  logic [NB_DIV-1:0]  div,
  output logic               o_ge,
  output logic [NB_DATA-1:0] o_dif
);

  logic [NB_DATA-1:0] div_ext;

  assign div_ext = {{(NB_DATA-NB_DIV){1'b0}}, div};
  assign o_ge    = (rem >= div_ext);
  assign o_dif   = rem - div_ext;

endmodule

// File: rtl/divisor_iterativo.sv
// Iterative unsigned divider: one subtraction per clock.
// Ports:
//   clk, i_rst_n : clock (rising edge), async active-low reset
//   i_start      : launch request, sampled only in IDLE
//   i_dividendo  : dividend (NB_DATA), i_divisor : divisor (NB_DIV)
//   o_cociente   : quotient, o_resto : remainder (registered)
//   o_div_cero   : last completed operation had a zero divisor
//   o_busy       : high in RUN, o_done : one-cycle pulse in DONE
module divisor_iterativo
  import divisor_iterativo_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_DIV  = NB_DIV_DEF
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [NB_DATA-1:0] i_dividendo,
  input  logic [NB_DIV-1:0]  i_divisor,
  output logic [NB_DATA-1:0] o_cociente,
  output logic [NB_DIV-1:0]  o_resto,
  output logic               o_div_cero,
  output logic               o_busy,
  output logic               o_done
);

  localparam logic [NB_DATA-1:0] QUO_ONE = {{(NB_DATA-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [NB_DATA-1:0] rem_q, rem_d;
  logic [NB_DATA-1:0] quo_q, quo_d;
  logic [NB_DIV-1:0]  div_q, div_d;
  logic [NB_DATA-1:0] coc_q, coc_d;
  logic [NB_DIV-1:0]  res_q, res_d;
  logic               dz_q, dz_d;

  logic               ge;
  logic [NB_DATA-1:0] dif;

  restador_comparador #(.NB_DATA(NB_DATA), .NB_DIV(NB_DIV)) u_rc (
    .rem   (rem_q),
    .div   (div_q),
    .o_ge  (ge),
    .o_dif (dif)
  );

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      coc_q   <= '0;
      res_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      coc_q   <= coc_d;
      res_q   <= res_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    div_d   = div_q;
    coc_d   = coc_q;
    res_d   = res_q;
    dz_d    = dz_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          if (i_divisor != '0) begin
            rem_d   = i_dividendo;
            quo_d   = '0;
            div_d   = i_divisor;
            state_d = ST_RUN;
          end else begin
            // Zero divisor skips RUN entirely and reports immediately.
            coc_d   = {NB_DATA{1'b1}};
            res_d   = '0;
            dz_d    = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        if (ge) begin
          rem_d = dif;
          quo_d = quo_q + QUO_ONE;
        end else begin
          // Final remainder is < div, so truncation loses nothing.
          coc_d   = quo_q;
          res_d   = rem_q[NB_DIV-1:0];
          dz_d    = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_cociente = coc_q;
  assign o_resto    = res_q;
  assign o_div_cero = dz_q;
  assign o_busy     = (state_q == ST_RUN);
  assign o_done     = (state_q == ST_DONE);

endmodule
